// File: rtl/nios0_vga_pixel_sched_if.sv
// Bus bundle for the VGA pixel scheduler: CPU Avalon-MM slave port, Sobel valid/ready
// stream and the VGA pixel sink, with the scheduler on the slave side.
interface nios0_vga_pixel_sched_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        s_valid;
  logic [23:0] s_data;
  logic        s_ready;
  logic [23:0] out_port;
  logic        out_strobe;
  logic        frame_done;

  modport master (
    output address, chipselect, write_n, writedata, s_valid, s_data,
    input  readdata, s_ready, out_port, out_strobe, frame_done
  );

  modport slave (
    input  address, chipselect, write_n, writedata, s_valid, s_data,
    output readdata, s_ready, out_port, out_strobe, frame_done
  );
endinterface

// File: rtl/nios0_vga_pixel_sched.sv
// Arbitrates CPU-written and Sobel-streamed pixels onto one 24-bit VGA pixel port,
// paces issues with a gap counter, tracks the raster position and flags frame completion.
module nios0_vga_pixel_sched #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int PIXEL_GAP = 1
) (
  input logic                     clk,
  input logic                     reset,
  nios0_vga_pixel_sched_if.slave  bus
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int GW = (PIXEL_GAP > 2) ? $clog2(PIXEL_GAP) : 1;

  localparam logic [XW-1:0] X_LAST   = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_RES - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((PIXEL_GAP > 0) ? PIXEL_GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_DISABLED,
    ST_READY,
    ST_GAP
  } state_t;

  typedef enum logic {
    GRANT_STREAM,
    GRANT_CPU
  } grant_t;

  state_t        state;
  grant_t        last_grant;
  logic [GW-1:0] gap_cnt;
  logic [23:0]   cpu_buf;
  logic          cpu_pend;
  logic          en;
  logic          cpu_prio;
  logic          frame_flag;
  logic          ovf;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [23:0]   out_port;
  logic          out_strobe;
  logic          frame_done;

  logic wr, wr_pixel, wr_ctrl, wr_status, wr_pos;
  logic stream_grant, stream_issue, cpu_issue, issue;
  logic x_last, at_last;

  // The top byte of the write bus carries nothing this block decodes.
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata[31:24];

  assign wr        = bus.chipselect && !bus.write_n;
  assign wr_pixel  = wr && (bus.address == 2'd0);
  assign wr_ctrl   = wr && (bus.address == 2'd1);
  assign wr_status = wr && (bus.address == 2'd2);
  assign wr_pos    = wr && (bus.address == 2'd3);

  // Stream grant depends on registers only, so s_ready never waits on s_valid.
  assign stream_grant = !cpu_pend || (!cpu_prio && (last_grant == GRANT_CPU));
  assign bus.s_ready  = (state == ST_READY) && stream_grant;
  assign stream_issue = bus.s_ready && bus.s_valid;
  assign cpu_issue    = (state == ST_READY) && cpu_pend && (!stream_grant || !bus.s_valid);
  assign issue        = stream_issue || cpu_issue;

  assign x_last  = (x == X_LAST);
  assign at_last = x_last && (y == Y_LAST);

  assign bus.out_port   = out_port;
  assign bus.out_strobe = out_strobe;
  assign bus.frame_done = frame_done;

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0: bus.readdata = {8'd0, out_port};
      2'd1: bus.readdata = {30'd0, cpu_prio, en};
      2'd2: bus.readdata = {29'd0, cpu_pend, ovf, frame_flag};
      2'd3: bus.readdata = {16'(y), 16'(x)};
      default: bus.readdata = '0;
    endcase
  end

  // NOTE: every register here, cpu_buf included, has a defined synchronous reset
  // value, so a mid-frame reset discards the partial frame and any pending CPU pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_DISABLED;
      last_grant <= GRANT_STREAM;
      gap_cnt    <= '0;
      cpu_buf    <= '0;
      cpu_pend   <= 1'b0;
      en         <= 1'b0;
      cpu_prio   <= 1'b0;
      frame_flag <= 1'b0;
      ovf        <= 1'b0;
      x          <= '0;
      y          <= '0;
      out_port   <= '0;
      out_strobe <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; every right-hand side below
      // sees the pre-edge register values, which the same-cycle rules rely on.
      out_strobe <= issue;
      frame_done <= issue && at_last;

      if (issue) begin
        out_port   <= cpu_issue ? cpu_buf : bus.s_data;
        last_grant <= cpu_issue ? GRANT_CPU : GRANT_STREAM;
      end

      if (wr_pixel) begin
        cpu_buf  <= bus.writedata[23:0];
        cpu_pend <= 1'b1;
      end else if (cpu_issue) begin
        cpu_pend <= 1'b0;
      end

      if (wr_ctrl) begin
        en       <= bus.writedata[0];
        cpu_prio <= bus.writedata[1];
      end

      // Sticky status bits: a set in the same cycle as a clear wins.
      if (issue && at_last)
        frame_flag <= 1'b1;
      else if (wr_status && bus.writedata[0])
        frame_flag <= 1'b0;

      if (wr_pixel && cpu_pend && !cpu_issue)
        ovf <= 1'b1;
      else if (wr_status && bus.writedata[1])
        ovf <= 1'b0;

      // An issue's own raster advance takes precedence over a POS write.
      if (issue) begin
        if (x_last) begin
          x <= '0;
          y <= (y == Y_LAST) ? '0 : y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end else if (wr_pos) begin
        x <= '0;
        y <= '0;
      end

      if (!en) begin
        state   <= ST_DISABLED;
        gap_cnt <= '0;
      end else begin
        case (state)
          ST_DISABLED: state <= ST_READY;
          ST_READY: begin
            if (issue && (PIXEL_GAP != 0)) begin
              gap_cnt <= GAP_LOAD;
              state   <= ST_GAP;
            end
          end
          ST_GAP: begin
            if (gap_cnt == '0)
              state <= ST_READY;
            else
              gap_cnt <= gap_cnt - GW'(1);
          end
          default: state <= ST_DISABLED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nios0_vga_pixel_sched.sv
// Scoreboard bench: a 4x2-raster, gap-free instance for arbitration/raster/status and a
// 640x480, two-cycle-gap instance for pacing.
module tb_nios0_vga_pixel_sched;

  localparam int TB_H = 4;
  localparam int TB_V = 2;

  typedef struct {
    logic [23:0] pix;
    logic        fd;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  nios0_vga_pixel_sched_if bi ();
  nios0_vga_pixel_sched_if bg ();

  nios0_vga_pixel_sched #(.H_RES(TB_H), .V_RES(TB_V), .PIXEL_GAP(0)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bi)
  );

  nios0_vga_pixel_sched #(.H_RES(640), .V_RES(480), .PIXEL_GAP(2)) u_gap (
    .clk   (clk),
    .reset (reset),
    .bus   (bg)
  );

  int   n_checks = 0;
  int   n_bad = 0;
  exp_t sb_q[$];
  int   exp_x = 0;
  int   exp_y = 0;
  logic exp_frame = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Queue the next expected pixel and advance the bench's own raster position.
  function automatic void push_exp(input logic [23:0] p);
    exp_t e;
    e.pix = p;
    e.fd  = (exp_x == TB_H - 1) && (exp_y == TB_V - 1);
    sb_q.push_back(e);
    if (exp_x == TB_H - 1) begin
      exp_x = 0;
      if (exp_y == TB_V - 1) begin
        exp_y = 0;
        exp_frame = 1'b1;
      end else begin
        exp_y++;
      end
    end else begin
      exp_x++;
    end
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (bi.out_strobe) begin
        if (sb_q.size() == 0) begin
          check("unexpected_strobe", 32'(bi.out_port), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check("out_port", 32'(bi.out_port), 32'(e.pix));
          check("frame_done", 32'(bi.frame_done), 32'(e.fd));
        end
      end else if (bi.frame_done) begin
        check("stray_frame_done", 32'(bi.frame_done), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bi.address    = a;
    bi.writedata  = d;
    bi.chipselect = 1'b1;
    bi.write_n    = 1'b0;
    tick();
    bi.chipselect = 1'b0;
    bi.write_n    = 1'b1;
    bi.address    = 2'd3;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bi.address = a;
    #1;
    d = bi.readdata;
    bi.address = 2'd3;
  endtask

  // Continuous stream for n cycles, with up to two CPU PIXEL writes (at cycles wa, wb)
  // and the cycles where the bench expects each of those CPU pixels to issue (ca, cb).
  task automatic stream_run(input int n, input int wa, input logic [23:0] da,
                            input int wb, input logic [23:0] db,
                            input int ca, input int cb, output int n_hs);
    logic hs;
    n_hs = 0;
    bi.s_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == wa || i == wb) begin
        bi.address    = 2'd0;
        bi.writedata  = {8'd0, (i == wa) ? da : db};
        bi.chipselect = 1'b1;
        bi.write_n    = 1'b0;
      end else begin
        bi.chipselect = 1'b0;
        bi.write_n    = 1'b1;
        bi.address    = 2'd3;
      end
      @(negedge clk);
      if (bi.address == 2'd3)
        check("pos", bi.readdata, {exp_y[15:0], exp_x[15:0]});
      hs = bi.s_ready;
      if (hs) begin
        push_exp(bi.s_data);
        n_hs++;
      end
      if (i == ca) push_exp(da);
      if (i == cb) push_exp(db);
      @(posedge clk);
      #1;
      if (hs) bi.s_data = bi.s_data + 24'd1;
    end
    bi.s_valid    = 1'b0;
    bi.chipselect = 1'b0;
    bi.write_n    = 1'b1;
    bi.address    = 2'd3;
  endtask

  initial begin
    logic [31:0] rdv;
    logic [23:0] gap_exp;
    logic        ghs;
    int          hs;

    bi.address = 2'd3; bi.chipselect = 1'b0; bi.write_n = 1'b1; bi.writedata = '0;
    bi.s_valid = 1'b0; bi.s_data = 24'd1;
    bg.address = 2'd0; bg.chipselect = 1'b0; bg.write_n = 1'b1; bg.writedata = '0;
    bg.s_valid = 1'b0; bg.s_data = 24'h000100;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    check("rst_s_ready", 32'(bi.s_ready), 32'd0);
    check("rst_strobe", 32'(bi.out_strobe), 32'd0);
    check("rst_frame_done", 32'(bi.frame_done), 32'd0);
    check("rst_gap_s_ready", 32'(bg.s_ready), 32'd0);
    rd(2'd0, rdv); check("rst_pixel", rdv, 32'd0);
    rd(2'd1, rdv); check("rst_ctrl", rdv, 32'd0);
    rd(2'd2, rdv); check("rst_status", rdv, 32'd0);
    rd(2'd3, rdv); check("rst_pos", rdv, 32'd0);

    // Back-to-back stream: one cycle DISABLED->READY, then a handshake every cycle
    wr(2'd1, 32'd1);
    stream_run(6, -1, 24'd0, -1, 24'd0, -1, -1, hs);
    check("t1_handshakes", 32'(hs), 32'd5);

    // CPU_PRIO=0: write slot goes to stream, then CPU; a write during the CPU issue
    // re-arms cpu_pend without OVF, and the stream gets the slot after a CPU grant
    stream_run(7, 2, 24'hABCDEF, 3, 24'h123456, 3, 5, hs);
    check("t3_rr_handshakes", 32'(hs), 32'd5);
    rd(2'd2, rdv); check("t3_rr_status", rdv, {29'd0, 1'b0, 1'b0, exp_frame});

    // CPU_PRIO=1: a pending CPU pixel always takes the next READY slot
    wr(2'd1, 32'd3);
    rd(2'd1, rdv); check("t3_ctrl", rdv, 32'd3);
    stream_run(7, 2, 24'hFEDCBA, 3, 24'h654321, 3, 4, hs);
    check("t3_prio_handshakes", 32'(hs), 32'd5);
    rd(2'd2, rdv); check("t3_prio_status", rdv, {29'd0, 1'b0, 1'b0, exp_frame});
    wr(2'd2, 32'd3);
    exp_frame = 1'b0;
    rd(2'd2, rdv); check("t3_status_clr", rdv, 32'd0);

    // Full 4x2 frame from POS=0
    wr(2'd1, 32'd1);
    wr(2'd3, 32'd0);
    exp_x = 0; exp_y = 0;
    rd(2'd3, rdv); check("t4_pos_zero", rdv, 32'd0);
    stream_run(8, -1, 24'd0, -1, 24'd0, -1, -1, hs);
    check("t4_handshakes", 32'(hs), 32'd8);
    rd(2'd3, rdv); check("t4_pos_wrap", rdv, 32'd0);
    rd(2'd2, rdv); check("t4_frame_set", rdv, 32'd1);
    wr(2'd2, 32'd1);
    exp_frame = 1'b0;
    rd(2'd2, rdv); check("t4_frame_clr", rdv, 32'd0);

    // Disabled: two CPU writes overflow, nothing issues; enabling issues the last one
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h111111);
    wr(2'd0, 32'h222222);
    tick(); tick();
    rd(2'd2, rdv); check("t5_ovf_pend", rdv, 32'd6);
    push_exp(24'h222222);
    wr(2'd1, 32'd1);
    tick(); tick(); tick();
    rd(2'd2, rdv); check("t5_pend_clr", rdv, 32'd2);
    check("t5_sb_empty", 32'(sb_q.size()), 32'd0);
    rd(2'd0, rdv); check("t5_pixel_rd", rdv, 32'h00222222);
    wr(2'd2, 32'd2);
    rd(2'd2, rdv); check("t5_ovf_clr", rdv, 32'd0);

    // Mid-frame reset with a pending CPU pixel
    stream_run(3, -1, 24'd0, -1, 24'd0, -1, -1, hs);
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h333333);
    rd(2'd2, rdv); check("t6_pend_before", rdv, 32'd4);
    reset = 1'b1;
    tick();
    check("t6_out_port", 32'(bi.out_port), 32'd0);
    check("t6_s_ready", 32'(bi.s_ready), 32'd0);
    check("t6_strobe", 32'(bi.out_strobe), 32'd0);
    rd(2'd3, rdv); check("t6_pos", rdv, 32'd0);
    rd(2'd2, rdv); check("t6_status", rdv, 32'd0);
    rd(2'd1, rdv); check("t6_ctrl", rdv, 32'd0);
    sb_q.delete();
    exp_x = 0; exp_y = 0; exp_frame = 1'b0;
    reset = 1'b0;
    tick();

    // Two-cycle gap: READY one cycle in three, strobe period three
    bg.address = 2'd1; bg.writedata = 32'd1; bg.chipselect = 1'b1; bg.write_n = 1'b0;
    tick();
    bg.chipselect = 1'b0; bg.write_n = 1'b1;
    bg.s_valid = 1'b1;
    gap_exp = 24'd0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      check("gap_s_ready", 32'(bg.s_ready), 32'((i >= 1) && ((i - 1) % 3 == 0)));
      check("gap_strobe", 32'(bg.out_strobe), 32'((i >= 2) && ((i - 2) % 3 == 0)));
      if (bg.out_strobe) check("gap_pixel", 32'(bg.out_port), 32'(gap_exp));
      ghs = bg.s_ready;
      if (ghs) gap_exp = bg.s_data;
      @(posedge clk);
      #1;
      if (ghs) bg.s_data = bg.s_data + 24'd1;
    end
    bg.s_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
